// File: rtl/fp_sc_pkg.sv
// Shared operand class codes and the canonical quiet-NaN pattern for the
// FP adder special-case stage.
package fp_sc_pkg;

  localparam logic [2:0] ZERO      = 3'd0;
  localparam logic [2:0] INF       = 3'd1;
  localparam logic [2:0] SUBNORMAL = 3'd2;
  localparam logic [2:0] NORMAL    = 3'd3;
  localparam logic [2:0] NAN       = 3'd4;

  // Positive quiet NaN: exponent all ones, only the mantissa MSB set.
  function automatic logic [63:0] canon_nan(input int exp_w, input int mant_w);
    logic [63:0] w;
    w = ((64'd1 << exp_w) - 64'd1) << mant_w;
    w = w | (64'd1 << (mant_w - 1));
    return w;
  endfunction

endpackage

// File: rtl/fp_special_cases_pipe_if.sv
// Valid/ready operand and result bundle of the FP adder special-case stage.
// slave = the stage itself, master = the driving/observing side.
interface fp_special_cases_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
);
  localparam int W = 1 + EXP_W + MANT_W;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         special_case;
  logic [2:0]   type_a;
  logic [2:0]   type_b;
  logic         eff_sign_b;

  modport slave (
    input  in_valid, op_sub, op_a, op_b, out_ready,
    output in_ready, out_valid, result, special_case, type_a, type_b, eff_sign_b
  );

  modport master (
    output in_valid, op_sub, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, special_case, type_a, type_b, eff_sign_b
  );
endinterface

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier: exponent/mantissa field -> class.
// The sign bit does not affect the class, so only {exp,mant} is supplied.
module fp_classify
  import fp_sc_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic [EXP_W+MANT_W-1:0] exp_man,
  output logic [2:0]              cls
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] man_f;

  assign exp_f = exp_man[MANT_W +: EXP_W];
  assign man_f = exp_man[MANT_W-1:0];

  always_comb begin
    cls = NORMAL;
    if (exp_f == '0) begin
      cls = (man_f == '0) ? ZERO : SUBNORMAL;
    end else if (&exp_f) begin
      cls = (man_f == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/fp_special_cases_pipe.sv
// Two-stage pre-adder special-case resolver for the FP adder (valid/ready both sides).
// Optional FP_SC_CANON_NAN_EN: every NaN result becomes the canonical quiet NaN.
module fp_special_cases_pipe
  import fp_sc_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  fp_special_cases_pipe_if.slave  bus
);

  localparam int W = 1 + EXP_W + MANT_W;

`ifdef FP_SC_CANON_NAN_EN
  localparam logic [63:0]  CANON_FULL = canon_nan(EXP_W, MANT_W);
  localparam logic [W-1:0] QNAN_W     = CANON_FULL[W-1:0];
`else
  localparam logic [W-1:0] INF_DIFF_NAN = {1'b1, {EXP_W{1'b1}}, {{(MANT_W-1){1'b0}}, 1'b1}};
`endif

  // NaN operand as it leaves the stage (rules 1-2).
  function automatic logic [W-1:0] nan_out(input logic [W-1:0] x);
`ifdef FP_SC_CANON_NAN_EN
    nan_out = (x == '0) ? QNAN_W : QNAN_W;
`else
    nan_out = x;
`endif
  endfunction

  // Priority resolver; returns {special_case, result}.
  function automatic logic [W:0] resolve(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] ta, input logic [2:0] tb,
                                         input logic sb);
    logic         sa;
    logic [W-1:0] b_eff;
    sa    = a[W-1];
    b_eff = {sb, b[W-2:0]};
    if (ta == NAN)                               resolve = {1'b1, nan_out(a)};
    else if (tb == NAN)                          resolve = {1'b1, nan_out(b)};
`ifdef FP_SC_CANON_NAN_EN
    else if (ta == INF && tb == INF && sa != sb) resolve = {1'b1, QNAN_W};
`else
    else if (ta == INF && tb == INF && sa != sb) resolve = {1'b1, INF_DIFF_NAN};
`endif
    else if (ta == INF)                          resolve = {1'b1, a};
    else if (tb == INF)                          resolve = {1'b1, b_eff};
    else if (ta == ZERO && tb == ZERO)           resolve = {1'b1, sa & sb, {(W-1){1'b0}}};
    else if (ta == ZERO)                         resolve = {1'b1, b_eff};
    else if (tb == ZERO)                         resolve = {1'b1, a};
    else                                         resolve = '0;
  endfunction

  logic [2:0] cls_a, cls_b;

  fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_a (
    .exp_man (bus.op_a[W-2:0]),
    .cls     (cls_a)
  );

  fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_b (
    .exp_man (bus.op_b[W-2:0]),
    .cls     (cls_b)
  );

  logic         vld_p1_q, vld_p1_d;
  logic [W-1:0] op_a_p1_q, op_a_p1_d;
  logic [W-1:0] op_b_p1_q, op_b_p1_d;
  logic         op_sub_p1_q, op_sub_p1_d;
  logic [2:0]   type_a_p1_q, type_a_p1_d;
  logic [2:0]   type_b_p1_q, type_b_p1_d;

  logic         vld_p2_q, vld_p2_d;
  logic [W-1:0] result_p2_q, result_p2_d;
  logic         special_p2_q, special_p2_d;
  logic [2:0]   type_a_p2_q, type_a_p2_d;
  logic [2:0]   type_b_p2_q, type_b_p2_d;
  logic         eff_sign_b_p2_q, eff_sign_b_p2_d;

  logic         adv_p2;
  logic         in_ready;
  logic         eff_sign_b_p1;
  logic [W:0]   res_p1;

  assign adv_p2        = !vld_p2_q || bus.out_ready;
  assign in_ready      = !vld_p1_q || adv_p2;
  assign eff_sign_b_p1 = op_b_p1_q[W-1] ^ op_sub_p1_q;
  assign res_p1        = resolve(op_a_p1_q, op_b_p1_q, type_a_p1_q, type_b_p1_q, eff_sign_b_p1);

  // Stage 1: capture operands and their classes
  always_comb begin
    vld_p1_d    = vld_p1_q;
    op_a_p1_d   = op_a_p1_q;
    op_b_p1_d   = op_b_p1_q;
    op_sub_p1_d = op_sub_p1_q;
    type_a_p1_d = type_a_p1_q;
    type_b_p1_d = type_b_p1_q;
    if (in_ready) begin
      vld_p1_d = bus.in_valid;
      if (bus.in_valid) begin
        op_a_p1_d   = bus.op_a;
        op_b_p1_d   = bus.op_b;
        op_sub_p1_d = bus.op_sub;
        type_a_p1_d = cls_a;
        type_b_p1_d = cls_b;
      end
    end
  end

  // Stage 2: register the resolved result and forwarded classes
  always_comb begin
    vld_p2_d        = vld_p2_q;
    result_p2_d     = result_p2_q;
    special_p2_d    = special_p2_q;
    type_a_p2_d     = type_a_p2_q;
    type_b_p2_d     = type_b_p2_q;
    eff_sign_b_p2_d = eff_sign_b_p2_q;
    if (adv_p2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        special_p2_d    = res_p1[W];
        result_p2_d     = res_p1[W-1:0];
        type_a_p2_d     = type_a_p1_q;
        type_b_p2_d     = type_b_p1_q;
        eff_sign_b_p2_d = eff_sign_b_p1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q        <= 1'b0;
      vld_p2_q        <= 1'b0;
      result_p2_q     <= '0;
      special_p2_q    <= 1'b0;
      type_a_p2_q     <= ZERO;
      type_b_p2_q     <= ZERO;
      eff_sign_b_p2_q <= 1'b0;
    end else begin
      vld_p1_q        <= vld_p1_d;
      vld_p2_q        <= vld_p2_d;
      result_p2_q     <= result_p2_d;
      special_p2_q    <= special_p2_d;
      type_a_p2_q     <= type_a_p2_d;
      type_b_p2_q     <= type_b_p2_d;
      eff_sign_b_p2_q <= eff_sign_b_p2_d;
    end
  end

  // Stage-1 payload is qualified by vld_p1_q, so it needs no reset.
  always_ff @(posedge clk) begin
    op_a_p1_q   <= op_a_p1_d;
    op_b_p1_q   <= op_b_p1_d;
    op_sub_p1_q <= op_sub_p1_d;
    type_a_p1_q <= type_a_p1_d;
    type_b_p1_q <= type_b_p1_d;
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = vld_p2_q;
  assign bus.result       = result_p2_q;
  assign bus.special_case = special_p2_q;
  assign bus.type_a       = type_a_p2_q;
  assign bus.type_b       = type_b_p2_q;
  assign bus.eff_sign_b   = eff_sign_b_p2_q;

endmodule

// File: tb/tb_fp_special_cases_pipe.sv
// Scoreboard bench for fp_special_cases_pipe at 32-bit defaults; honours
// FP_SC_CANON_NAN_EN in its reference model.
module tb_fp_special_cases_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        sc;
    logic [2:0]  ta;
    logic [2:0]  tb;
    logic        esb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_special_cases_pipe_if bus ();

  fp_special_cases_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s got=%h want=%h", tag, got, want);
    else n_pass++;
  endtask

  function automatic logic [2:0] cls32(input logic [31:0] x);
    if (x[30:23] == 8'h00) return (x[22:0] == 23'd0) ? 3'd0 : 3'd2;
    if (x[30:23] == 8'hFF) return (x[22:0] == 23'd0) ? 3'd1 : 3'd4;
    return 3'd3;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    logic sb;
    sb    = b[31] ^ s;
    e.ta  = cls32(a);
    e.tb  = cls32(b);
    e.esb = sb;
    e.sc  = 1'b1;
`ifdef FP_SC_CANON_NAN_EN
    if (e.ta == 3'd4 || e.tb == 3'd4)                       e.res = 32'h7FC00000;
    else if (e.ta == 3'd1 && e.tb == 3'd1 && a[31] != sb)  e.res = 32'h7FC00000;
`else
    if (e.ta == 3'd4)                                       e.res = a;
    else if (e.tb == 3'd4)                                  e.res = b;
    else if (e.ta == 3'd1 && e.tb == 3'd1 && a[31] != sb)  e.res = 32'hFF800001;
`endif
    else if (e.ta == 3'd1)                                  e.res = a;
    else if (e.tb == 3'd1)                                  e.res = {sb, b[30:0]};
    else if (e.ta == 3'd0 && e.tb == 3'd0)                  e.res = {a[31] & sb, 31'd0};
    else if (e.ta == 3'd0)                                  e.res = {sb, b[30:0]};
    else if (e.tb == 3'd0)                                  e.res = a;
    else begin
      e.sc  = 1'b0;
      e.res = 32'd0;
    end
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    int waited;
    bit done;
    waited = 0;
    done   = 1'b0;
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_sub   = s;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(model(a, b, s));
        done = 1'b1;
      end else if (++waited > 200) begin
        check("accept_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return 32'h7F800000;
      3: return 32'hFF800000;
      4: return 32'h7FC00001;
      5: return 32'hFF812345;
      6: return 32'h00000003;
      7: return 32'h807FFFFF;
      8: return 32'h3F800000;
      default: return $urandom;
    endcase
  endfunction

  // Output monitor: scoreboard pop plus held-output stability while stalled.
  logic [38:0] held;
  bit          prev_stalled = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stalled = 1'b0;
    end else begin
      if (prev_stalled && bus.out_valid)
        check("hold_stable", 64'({bus.result, bus.special_case, bus.type_a, bus.type_b, bus.eff_sign_b}),
              64'(held));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("sb_unexpected_out", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("result",       64'(bus.result),       64'(e.res));
          check("special_case", 64'(bus.special_case), 64'(e.sc));
          check("type_a",       64'(bus.type_a),       64'(e.ta));
          check("type_b",       64'(bus.type_b),       64'(e.tb));
          check("eff_sign_b",   64'(bus.eff_sign_b),   64'(e.esb));
        end
      end
      prev_stalled = bus.out_valid && !bus.out_ready;
      held = {bus.result, bus.special_case, bus.type_a, bus.type_b, bus.eff_sign_b};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid",    64'(bus.out_valid),    64'd0);
    check("rst_result",       64'(bus.result),       64'd0);
    check("rst_special_case", 64'(bus.special_case), 64'd0);
    check("rst_types",        64'({bus.type_a, bus.type_b}), 64'd0);
    check("rst_eff_sign_b",   64'(bus.eff_sign_b),   64'd0);
    check("rst_in_ready",     64'(bus.in_ready),     64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed special-case vectors
    send(32'h3F800000, 32'h40000000, 1'b0);
    send(32'h7F800000, 32'hFF800000, 1'b0);
    send(32'h00000000, 32'h00000000, 1'b1);
    send(32'h80000000, 32'h80000000, 1'b0);
    send(32'h00000000, 32'h3F800000, 1'b1);
    send(32'h7FC12345, 32'h3F800000, 1'b0);
    send(32'h3F800000, 32'hFF812345, 1'b1);
    send(32'h7F800000, 32'h7F800000, 1'b1);
    send(32'h7F800000, 32'h7F800000, 1'b0);
    send(32'h3F800000, 32'h80000000, 1'b0);
    send(32'h00000001, 32'h3F800000, 1'b0);
    send(32'h40400000, 32'hFF800000, 1'b1);
    drain();

    // Back-to-back stream with a three-cycle downstream stall
    fork
      begin
        send(32'h3F800000, 32'h40000000, 1'b0);
        send(32'h7F800000, 32'h00000000, 1'b1);
        send(32'h80000000, 32'h00000000, 1'b0);
        send(32'h00000005, 32'h7FC00000, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full, then single-pair latency
    bus.out_ready = 1'b0;
    send(32'h3F800000, 32'h00000000, 1'b0);
    send(32'h7F800000, 32'h3F800000, 1'b0);
    check("full_out_valid", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.op_a     = 32'h00000000;
    bus.op_b     = 32'hC0000000;
    bus.op_sub   = 1'b1;
    @(negedge clk);
    check("lat_accept", 64'(bus.in_ready), 64'd1);
    q.push_back(model(32'h00000000, 32'hC0000000, 1'b1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("lat_1cycle_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_2cycle_out_valid", 64'(bus.out_valid), 64'd1);
    drain();

    // Random operand pairs drawn from a boundary-heavy table
    for (int i = 0; i < 30; i++) send(pick(), pick(), 1'($urandom_range(0, 1)));
    drain();

    repeat (3) @(posedge clk);
    #1;
    check("final_out_valid", 64'(bus.out_valid), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
